// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for the shared PL-side BRAM port, with optional burst locking.
// Define BRAM_ARB_STARVE_LIMIT_EN to cap locked bursts at MAX_BURST beats when the other side waits.
module bram_port_arbiter #(
    parameter int          RD_LATENCY = 1,
    parameter logic [15:0] MAX_BURST  = 16'd256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [3:0]  m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_lock,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [3:0]  m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_lock,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        bram_en,
    output logic [3:0]  bram_we,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_dout,
    output logic        bram_rst,
    input  logic [31:0] bram_din
);

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_LOCK0,
        ARB_LOCK1
    } arb_state_t;

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_last;
    logic       w_last_nxt;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_acc;
    logic       w_lock;
    logic       w_starve;
    logic [3:0] w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;

    logic        r_en;
    logic [3:0]  r_we;
    logic [31:0] r_addr;
    logic [31:0] r_dout;

    // Bit k carries a read tag k+1 cycles after acceptance.
    logic [RD_LATENCY:0] r_tag_v;
    logic [RD_LATENCY:0] r_tag_id;
    logic                w_rv;

`ifdef BRAM_ARB_STARVE_LIMIT_EN
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;

    always_comb begin
        w_starve = 1'b0;
        if (r_cnt >= MAX_BURST) begin
            w_starve = ((r_state == ARB_LOCK0) && m1_req) ||
                       ((r_state == ARB_LOCK1) && m0_req);
        end
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_state_nxt == ARB_IDLE) begin
            w_cnt_nxt = 16'd0;
        end else if (w_acc) begin
            if (r_state == ARB_IDLE) begin
                w_cnt_nxt = 16'd1;
            end else if (r_cnt != 16'hFFFF) begin
                w_cnt_nxt = r_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`else
    assign w_starve = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        unique case (r_state)
            ARB_IDLE: begin
                if (m0_req && (!m1_req || r_last)) begin
                    w_gnt0 = 1'b1;
                end else if (m1_req) begin
                    w_gnt1 = 1'b1;
                end
            end
            ARB_LOCK0: begin
                if (w_starve) begin
                    w_state_nxt = ARB_IDLE;
                    w_last_nxt  = 1'b0;
                end else if (m0_req) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            ARB_LOCK1: begin
                if (w_starve) begin
                    w_state_nxt = ARB_IDLE;
                    w_last_nxt  = 1'b1;
                end else if (m1_req) begin
                    w_gnt1 = 1'b1;
                end else begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
        if (rst) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
        if (w_gnt0) begin
            w_last_nxt  = 1'b0;
            w_state_nxt = m0_lock ? ARB_LOCK0 : ARB_IDLE;
        end
        if (w_gnt1) begin
            w_last_nxt  = 1'b1;
            w_state_nxt = m1_lock ? ARB_LOCK1 : ARB_IDLE;
        end
    end

    always_comb begin
        w_acc   = w_gnt0 | w_gnt1;
        w_we    = w_gnt1 ? m1_we    : m0_we;
        w_addr  = w_gnt1 ? m1_addr  : m0_addr;
        w_wdata = w_gnt1 ? m1_wdata : m0_wdata;
        w_lock  = w_gnt1 ? m1_lock  : m0_lock;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ARB_IDLE;
            r_last   <= 1'b1;
            r_en     <= 1'b0;
            r_we     <= 4'h0;
            r_addr   <= 32'h0;
            r_dout   <= 32'h0;
            r_tag_v  <= '0;
            r_tag_id <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_last   <= w_last_nxt;
            r_en     <= w_acc;
            r_we     <= w_acc ? w_we : 4'h0;
            if (w_acc) begin
                r_addr <= w_addr;
                r_dout <= w_wdata;
            end
            r_tag_v  <= {r_tag_v[RD_LATENCY-1:0], w_acc && (w_we == 4'h0)};
            r_tag_id <= {r_tag_id[RD_LATENCY-1:0], w_gnt1};
        end
    end

    assign w_rv      = r_tag_v[RD_LATENCY] & ~rst;
    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign m0_rvalid = w_rv & ~r_tag_id[RD_LATENCY];
    assign m1_rvalid = w_rv & r_tag_id[RD_LATENCY];
    assign m0_rdata  = m0_rvalid ? bram_din : 32'h0;
    assign m1_rdata  = m1_rvalid ? bram_din : 32'h0;
    assign bram_en   = r_en;
    assign bram_we   = r_we;
    assign bram_addr = r_addr;
    assign bram_dout = r_dout;
    assign bram_rst  = 1'b0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter with a behavioural BRAM and arbitration model.
module tb_bram_port_arbiter;

    localparam int          LAT = 2;
    localparam logic [15:0] MB  = 16'd8;
`ifdef BRAM_ARB_STARVE_LIMIT_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m0_req = 1'b0, m1_req = 1'b0;
    logic [3:0] m0_we = 4'h0, m1_we = 4'h0;
    logic [31:0] m0_addr = 32'h0, m1_addr = 32'h0;
    logic [31:0] m0_wdata = 32'h0, m1_wdata = 32'h0;
    logic m0_lock = 1'b0, m1_lock = 1'b0;
    logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic bram_en, bram_rst;
    logic [3:0] bram_we;
    logic [31:0] bram_addr, bram_dout, bram_din;

    bram_port_arbiter #(.RD_LATENCY(LAT), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_dout(bram_dout), .bram_rst(bram_rst), .bram_din(bram_din)
    );

    always #5 clk = ~clk;

    // Behavioural BRAM: read-first, LAT cycles from registered en to din.
    logic [31:0] ram [256];
    logic [31:0] dpipe [LAT];
    logic mem_clr = 1'b1;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
        end else if (bram_en) begin
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) ram[bram_addr[9:2]][8*b+:8] <= bram_dout[8*b+:8];
        end
        dpipe[0] <= ram[bram_addr[9:2]];
        for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
    end
    assign bram_din = dpipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;
    rd_t q0[$];
    rd_t q1[$];

    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] gmem [256];
    int   owner = -1;
    bit   last = 1'b1;
    int   bcnt = 0;
    bit   started = 1'b0;
    bit   m_acc0 = 1'b0, m_acc1 = 1'b0;
    logic [1:0] s_g;
    logic e_en = 1'b0;
    logic [3:0] e_we = 4'h0;
    logic [31:0] e_addr = 32'h0, e_dout = 32'h0;
    logic [31:0] last_rd0 = 32'h0, last_rd1 = 32'h0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b+:8] = d[8*b+:8];
        return r;
    endfunction

    task automatic step();
        int w;
        logic [3:0] we;
        logic [31:0] a, d;
        logic lk, own_req, oth_req;
        rd_t e;
        @(negedge clk);
        if (started) begin
            n_tests++;
            if ({bram_en, bram_we, bram_addr, bram_dout, bram_rst} !==
                {e_en, e_we, e_addr, e_dout, 1'b0}) begin
                n_fail++;
                $display("FAIL bram_port cyc %0d: got en=%b we=%h a=%h d=%h rst=%b want en=%b we=%h a=%h d=%h",
                         cyc, bram_en, bram_we, bram_addr, bram_dout, bram_rst,
                         e_en, e_we, e_addr, e_dout);
            end
        end
        w = -1;
        if (rst) begin
            owner = -1; last = 1'b1; bcnt = 0;
            n_tests++;
            if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== '0) begin
                n_fail++;
                $display("FAIL reset_rd cyc %0d: rvalid=%b%b, want 00 and zero data",
                         cyc, m1_rvalid, m0_rvalid);
            end
        end else if (owner < 0) begin
            if (m0_req && m1_req) w = last ? 0 : 1;
            else if (m0_req) w = 0;
            else if (m1_req) w = 1;
        end else begin
            own_req = (owner == 0) ? m0_req : m1_req;
            oth_req = (owner == 0) ? m1_req : m0_req;
            if (STARVE && bcnt >= int'(MB) && oth_req) begin
                last = owner[0]; owner = -1; bcnt = 0;
            end else if (own_req) begin
                w = owner;
            end else begin
                owner = -1; bcnt = 0;
            end
        end
        s_g = {m1_gnt, m0_gnt};
        n_tests++;
        if (s_g !== {w == 1, w == 0}) begin
            n_fail++;
            $display("FAIL gnt cyc %0d: got %b want %b", cyc, s_g, {w == 1, w == 0});
        end
        m_acc0 = (w == 0);
        m_acc1 = (w == 1);
        if (w >= 0) begin
            we = w ? m1_we : m0_we;
            a  = w ? m1_addr : m0_addr;
            d  = w ? m1_wdata : m0_wdata;
            lk = w ? m1_lock : m0_lock;
            last = w[0];
            if (lk) begin
                if (owner == w) bcnt++;
                else begin owner = w; bcnt = 1; end
            end else begin
                owner = -1; bcnt = 0;
            end
            e_en = 1'b1; e_we = we; e_addr = a; e_dout = d;
            if (we == 4'h0) begin
                e.due = cyc + 1 + LAT;
                e.data = gmem[a[9:2]];
                if (w == 0) q0.push_back(e); else q1.push_back(e);
            end else begin
                gmem[a[9:2]] = merge(gmem[a[9:2]], d, we);
            end
        end else begin
            e_en = 1'b0; e_we = 4'h0;
            if (rst) begin e_addr = 32'h0; e_dout = 32'h0; end
        end
        started = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected read returns as the DUT presents them.
    always @(negedge clk) begin
        rd_t e;
        if (!rst && started) begin
            if (m0_rvalid) begin
                n_tests++;
                last_rd0 = m0_rdata;
                if (q0.size() == 0) begin
                    n_fail++;
                    $display("FAIL rvalid0 cyc %0d: unexpected, data %h", cyc, m0_rdata);
                end else begin
                    e = q0.pop_front();
                    if (e.data !== m0_rdata || e.due != cyc) begin
                        n_fail++;
                        $display("FAIL rdata0 cyc %0d: got %h want %h at cyc %0d",
                                 cyc, m0_rdata, e.data, e.due);
                    end
                end
            end else if (q0.size() != 0 && q0[0].due <= cyc) begin
                n_tests++; n_fail++;
                $display("FAIL rvalid0 cyc %0d: missing, want %h", cyc, q0[0].data);
                void'(q0.pop_front());
            end
            if (m1_rvalid) begin
                n_tests++;
                last_rd1 = m1_rdata;
                if (q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL rvalid1 cyc %0d: unexpected, data %h", cyc, m1_rdata);
                end else begin
                    e = q1.pop_front();
                    if (e.data !== m1_rdata || e.due != cyc) begin
                        n_fail++;
                        $display("FAIL rdata1 cyc %0d: got %h want %h at cyc %0d",
                                 cyc, m1_rdata, e.data, e.due);
                    end
                end
            end else if (q1.size() != 0 && q1[0].due <= cyc) begin
                n_tests++; n_fail++;
                $display("FAIL rvalid1 cyc %0d: missing, want %h", cyc, q1[0].data);
                void'(q1.pop_front());
            end
            if ((!m0_rvalid && m0_rdata !== 32'h0) || (!m1_rvalid && m1_rdata !== 32'h0)) begin
                n_tests++; n_fail++;
                $display("FAIL rdata_idle cyc %0d: got %h %h want 0", cyc, m0_rdata, m1_rdata);
            end
        end
    end

    task automatic setb(input int id, input logic [3:0] we, input logic [31:0] a,
                        input logic [31:0] d, input logic lk);
        if (id == 0) begin
            m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; m0_lock = lk;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; m1_lock = lk;
        end
    endtask

    task automatic wait_acc(input int id);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!(id == 0 ? m_acc0 : m_acc1) && k < 64);
        if (!(id == 0 ? m_acc0 : m_acc1)) begin
            n_tests++; n_fail++;
            $display("FAIL wait_acc%0d: no grant within 64 cycles", id);
        end
        if (id == 0) m0_req = 1'b0; else m1_req = 1'b0;
    endtask

    task automatic drain(input int n);
        m0_req = 1'b0; m1_req = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        q0.delete(); q1.delete();
        for (int i = 0; i < n; i++) step();
        rst = 1'b0;
    endtask

    task automatic rnd_beat(input int id);
        logic [3:0] we;
        int r;
        r = $urandom_range(0, 3);
        we = (r < 2) ? 4'h0 : (r == 2) ? 4'hF : 4'($urandom_range(1, 15));
        setb(id, we, {22'h0, 8'($urandom_range(0, 255)), 2'b00}, $urandom,
             $urandom_range(0, 4) == 0);
    endtask

    initial begin
        int cnt0;
        bit got1;
        for (int i = 0; i < 256; i++) gmem[i] = 32'h0;
        step();
        step();
        mem_clr = 1'b0;
        rst = 1'b0;
        step();

        // Tie round-robin straight after reset.
        setb(0, 4'h0, 32'h40, 32'h0, 1'b0);
        setb(1, 4'h0, 32'h44, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (s_g !== ((i % 2) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL rr_order beat %0d: got %b want %b", i, s_g,
                         (i % 2) ? 2'b10 : 2'b01);
            end
        end
        drain(6);

        // Locked write burst from m0 while m1 waits.
        setb(1, 4'h0, 32'h10C, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            setb(0, 4'hF, 32'h100 + 32'(4 * i), 32'(i), i < 3);
            step();
            n_tests++;
            if (s_g !== 2'b01) begin
                n_fail++;
                $display("FAIL burst_gnt beat %0d: got %b want 01", i, s_g);
            end
        end
        m0_req = 1'b0;
        step();
        n_tests++;
        if (s_g !== 2'b10) begin
            n_fail++;
            $display("FAIL burst_release: got %b want 10", s_g);
        end
        drain(6);
        n_tests++;
        if (last_rd1 !== 32'd3) begin
            n_fail++;
            $display("FAIL burst_data: got %h want 00000003", last_rd1);
        end

        // Single write then read from m0.
        setb(0, 4'hF, 32'h10, 32'hCAFE0010, 1'b0);
        wait_acc(0);
        setb(0, 4'h0, 32'h10, 32'h0, 1'b0);
        wait_acc(0);
        drain(6);
        n_tests++;
        if (last_rd0 !== 32'hCAFE0010) begin
            n_fail++;
            $display("FAIL single_read: got %h want cafe0010", last_rd0);
        end

        // Byte-enable write from m1.
        setb(0, 4'hF, 32'h20, 32'h11223344, 1'b0);
        wait_acc(0);
        setb(1, 4'b0011, 32'h20, 32'hAABBCCDD, 1'b0);
        wait_acc(1);
        setb(1, 4'h0, 32'h20, 32'h0, 1'b0);
        wait_acc(1);
        drain(6);
        n_tests++;
        if (last_rd1 !== 32'h1122CCDD) begin
            n_fail++;
            $display("FAIL byte_write: got %h want 1122ccdd", last_rd1);
        end

        // m0 holds the lock indefinitely while m1 waits.
        setb(0, 4'hF, 32'h200, $urandom, 1'b1);
        step();
        cnt0 = s_g[0] ? 1 : 0;
        setb(1, 4'h0, 32'h200, 32'h0, 1'b0);
        got1 = 1'b0;
        for (int k = 0; k < 100 && !got1; k++) begin
            step();
            if (s_g[1]) got1 = 1'b1;
            else if (s_g[0]) cnt0++;
            m0_wdata = $urandom;
        end
        n_tests++;
`ifdef BRAM_ARB_STARVE_LIMIT_EN
        if (!got1 || cnt0 != 8) begin
            n_fail++;
            $display("FAIL starve: m1 granted=%0d after %0d m0 beats, want 1 after 8", got1, cnt0);
        end
`else
        if (got1) begin
            n_fail++;
            $display("FAIL starve: m1 granted=1 after %0d m0 beats, want 0 in 100", cnt0);
        end
`endif
        m0_req = 1'b0;
        if (got1) m1_req = 1'b0;
        else wait_acc(1);
        drain(6);

        // Reset in the cycle after a read is accepted.
        setb(0, 4'h0, 32'h200, 32'h0, 1'b0);
        wait_acc(0);
        do_reset(2);
        setb(0, 4'h0, 32'h204, 32'h0, 1'b0);
        setb(1, 4'h0, 32'h208, 32'h0, 1'b0);
        step();
        n_tests++;
        if (s_g !== 2'b01) begin
            n_fail++;
            $display("FAIL post_reset_tie: got %b want 01", s_g);
        end
        m0_req = 1'b0;
        wait_acc(1);
        drain(6);

        // Randomized traffic on both requesters.
        for (int c = 0; c < 3000; c++) begin
            if (!m0_req || m_acc0) begin
                if ($urandom_range(0, 9) < 6) rnd_beat(0); else m0_req = 1'b0;
            end
            if (!m1_req || m_acc1) begin
                if ($urandom_range(0, 9) < 6) rnd_beat(1); else m1_req = 1'b0;
            end
            step();
        end
        drain(10);
        n_tests++;
        if (q0.size() + q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d reads still outstanding, want 0", q0.size() + q1.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
